alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter that shares the single combinational 32-bit ALU between two requesters: the main pipeline (port 0) and the multi-cycle unit (port 1). Each port has a valid/ready request channel carrying operation, operands and shift amount, and a valid/ready response channel carrying the result and flags. The block selects at most one request per cycle, drives the ALU with it, and registers the ALU outputs into that port's response register. It sits between the requesters and the ALU instance in the execute stage.

## Interface
- DATA_WIDTH, 32, operand/result width
- ALU_CTRL_WIDTH, 5, ALU operation code width (passed through opaquely)
- AMOUNT_WIDTH, 5, shift-amount width (log2 DATA_WIDTH)
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins
- i_clk  input  1  clock; all state updates on its rising edge
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- i_reqN_valid  input  1  port N (N = 0, 1) request valid
- o_reqN_ready  output  1  port N request accepted this cycle (grant)
- i_reqN_op  input  ALU_CTRL_WIDTH  port N ALU operation
- i_reqN_a, i_reqN_b  input  DATA_WIDTH  port N operands
- i_reqN_sa  input  AMOUNT_WIDTH  port N shift amount
- o_rspN_valid  output  1  port N response register full
- i_rspN_ready  input  1  port N consumes its response
- o_rspN_data  output  DATA_WIDTH  port N registered result
- o_rspN_zero, o_rspN_ovf  output  1  port N registered zero/overflow flags
- o_alu_operation  output  ALU_CTRL_WIDTH  to ALU i_operation
- o_alu_data_a, o_alu_data_b  output  DATA_WIDTH  to ALU operands
- o_alu_sa  output  AMOUNT_WIDTH  to ALU i_sa
- i_alu_dout  input  DATA_WIDTH  from ALU o_dout
- i_alu_zero, i_alu_ovf  input  1  from ALU flags

## Operation
- Eligibility: port N is eligible when i_reqN_valid = 1 and (o_rspN_valid = 0 or i_rspN_ready = 1). A full response register that drains in the same cycle frees the port.
- Arbitration: if exactly one port is eligible, it is granted. If both are eligible: with FIXED_PRIO = 1, port 0 wins; with FIXED_PRIO = 0, the port named by the 1-bit priority pointer wins.
- The pointer updates only on a grant, to the port that was not granted. It holds on idle cycles. With FIXED_PRIO = 1 it is unused.
- Grant: o_reqN_ready = 1 for the winner only. At most one ready is high per cycle.
- ALU mux: on a grant, the o_alu_* outputs carry the winner's op/a/b/sa combinationally. With no grant, all o_alu_* outputs are 0.
- Capture: on a grant to port N, at the clock edge, rspN_data/zero/ovf <= i_alu_dout/i_alu_zero/i_alu_ovf and o_rspN_valid <= 1.
- Drain: o_rspN_valid & i_rspN_ready with no new grant to N clears o_rspN_valid. Data registers hold their value.
- Simultaneous drain and grant on the same port: the new result is loaded and valid stays 1 (one-entry pass-through, no bubble).
- The response register of the non-granted port is unaffected except by its own drain.
- Requesters must not make valid depend combinationally on ready. Once valid is asserted, op/a/b/sa are held until the grant.

## Timing
- Reset (asynchronous assert, synchronous release): o_rsp0_valid = o_rsp1_valid = 0, all o_rspN_data/zero/ovf = 0, priority pointer = port 0, o_reqN_ready = 0.
- Latency: request granted in cycle t → o_rspN_valid = 1 with the result in cycle t+1.
- Throughput: one ALU operation per cycle in total. A single port sustains one per cycle while its i_rspN_ready stays 1.
- Back-pressure: with o_rspN_valid = 1 and i_rspN_ready = 0, port N is not granted. The other port may use the ALU.
- Reset asserted mid-operation discards any pending response immediately, and the pointer returns to 0.

## Test plan
- Reset: hold i_rst_n = 0 with both valids high → both readys 0, both rsp_valid 0, all o_alu_* 0. Release → port 0 is granted first.
- Single port: port 0 issues ADD with a = 5, b = 7, i_rsp0_ready = 1 → o_req0_ready = 1 in cycle t; in t+1, o_rsp0_valid = 1, data = 12, zero = 0, ovf = 0.
- Round-robin contention: both ports stream ADDs (port 0 a = 1, b = i; port 1 a = 0x7FFFFFFF, b = 1) with rsp_ready = 1 → grants alternate 0,1,0,1. Port 1 results are 0x80000000 with ovf = 1.
- Fixed priority: FIXED_PRIO = 1 with both ports continuously valid → port 0 is granted every cycle and port 1 never. Dropping port 0 valid for one cycle → port 1 is granted that cycle.
- Back-pressure: i_rsp0_ready = 0 with port 0 valid and its response full → port 0 is not granted and its result holds. Port 1 SUB with a = 3, b = 3 is granted, giving data = 0, zero = 1. Raising i_rsp0_ready → port 0 drains and is re-granted in the same cycle, with valid staying 1.
- Mid-operation reset: assert i_rst_n = 0 asynchronously while o_rsp1_valid = 1 → o_rsp1_valid drops before the next edge. After release, the pointer is back at port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU between the main pipeline (port 0)
// and the multi-cycle unit (port 1), with a one-entry registered response per port.
module alu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int AMOUNT_WIDTH   = 5,
    parameter int FIXED_PRIO     = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req0_valid,
    output logic                      o_req0_ready,
    input  logic [ALU_CTRL_WIDTH-1:0] i_req0_op,
    input  logic [DATA_WIDTH-1:0]     i_req0_a,
    input  logic [DATA_WIDTH-1:0]     i_req0_b,
    input  logic [AMOUNT_WIDTH-1:0]   i_req0_sa,
    input  logic                      i_req1_valid,
    output logic                      o_req1_ready,
    input  logic [ALU_CTRL_WIDTH-1:0] i_req1_op,
    input  logic [DATA_WIDTH-1:0]     i_req1_a,
    input  logic [DATA_WIDTH-1:0]     i_req1_b,
    input  logic [AMOUNT_WIDTH-1:0]   i_req1_sa,
    output logic                      o_rsp0_valid,
    input  logic                      i_rsp0_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp0_data,
    output logic                      o_rsp0_zero,
    output logic                      o_rsp0_ovf,
    output logic                      o_rsp1_valid,
    input  logic                      i_rsp1_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp1_data,
    output logic                      o_rsp1_zero,
    output logic                      o_rsp1_ovf,
    output logic [ALU_CTRL_WIDTH-1:0] o_alu_operation,
    output logic [DATA_WIDTH-1:0]     o_alu_data_a,
    output logic [DATA_WIDTH-1:0]     o_alu_data_b,
    output logic [AMOUNT_WIDTH-1:0]   o_alu_sa,
    input  logic [DATA_WIDTH-1:0]     i_alu_dout,
    input  logic                      i_alu_zero,
    input  logic                      i_alu_ovf
);

    // Handshake: a request transfers in the cycle where valid and ready are both high;
    // a response transfers when o_rspN_valid and i_rspN_ready are both high. Ready on
    // the request side is the grant and depends combinationally on valid, never the reverse.
    logic [1:0]            req_valid;
    logic [1:0]            rsp_ready;
    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic                  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic                  rsp0_zero_q, rsp0_zero_d, rsp0_ovf_q, rsp0_ovf_d;
    logic                  rsp1_zero_q, rsp1_zero_d, rsp1_ovf_q, rsp1_ovf_d;

    assign req_valid = {i_req1_valid, i_req0_valid};
    assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};
    // A response slot that drains this cycle can accept the next result.
    assign eligible  = req_valid & (~rsp_valid_q | rsp_ready) & {2{i_rst_n}};

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ((FIXED_PRIO != 0) || !ptr_q) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        o_alu_operation = '0;
        o_alu_data_a    = '0;
        o_alu_data_b    = '0;
        o_alu_sa        = '0;
        if (grant[0]) begin
            o_alu_operation = i_req0_op;
            o_alu_data_a    = i_req0_a;
            o_alu_data_b    = i_req0_b;
            o_alu_sa        = i_req0_sa;
        end else if (grant[1]) begin
            o_alu_operation = i_req1_op;
            o_alu_data_a    = i_req1_a;
            o_alu_data_b    = i_req1_b;
            o_alu_sa        = i_req1_sa;
        end
    end

    always_comb begin
        rsp_valid_d = (rsp_valid_q & ~rsp_ready) | grant;
        ptr_d       = grant[0] ? 1'b1 : (grant[1] ? 1'b0 : ptr_q);
        rsp0_data_d = grant[0] ? i_alu_dout : rsp0_data_q;
        rsp0_zero_d = grant[0] ? i_alu_zero : rsp0_zero_q;
        rsp0_ovf_d  = grant[0] ? i_alu_ovf  : rsp0_ovf_q;
        rsp1_data_d = grant[1] ? i_alu_dout : rsp1_data_q;
        rsp1_zero_d = grant[1] ? i_alu_zero : rsp1_zero_q;
        rsp1_ovf_d  = grant[1] ? i_alu_ovf  : rsp1_ovf_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 2'b00;
            ptr_q       <= 1'b0;
            rsp0_data_q <= '0;
            rsp0_zero_q <= 1'b0;
            rsp0_ovf_q  <= 1'b0;
            rsp1_data_q <= '0;
            rsp1_zero_q <= 1'b0;
            rsp1_ovf_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            ptr_q       <= ptr_d;
            rsp0_data_q <= rsp0_data_d;
            rsp0_zero_q <= rsp0_zero_d;
            rsp0_ovf_q  <= rsp0_ovf_d;
            rsp1_data_q <= rsp1_data_d;
            rsp1_zero_q <= rsp1_zero_d;
            rsp1_ovf_q  <= rsp1_ovf_d;
        end
    end

    assign o_req0_ready = grant[0];
    assign o_req1_ready = grant[1];
    assign o_rsp0_valid = rsp_valid_q[0];
    assign o_rsp1_valid = rsp_valid_q[1];
    assign o_rsp0_data  = rsp0_data_q;
    assign o_rsp0_zero  = rsp0_zero_q;
    assign o_rsp0_ovf   = rsp0_ovf_q;
    assign o_rsp1_data  = rsp1_data_q;
    assign o_rsp1_zero  = rsp1_zero_q;
    assign o_rsp1_ovf   = rsp1_ovf_q;

endmodule
